// File: rtl/cbus_arbiter.sv
// Round-robin arbiter merging the instruction- and data-side cbus masters onto one
// downstream cbus port; a grant is held for a whole burst and responses go back to the owner.
module cbus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned LEN_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_valid,
    input  logic [NUM_MASTERS-1:0]        m_is_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*3-1:0]      m_size,
    input  logic [NUM_MASTERS*8-1:0]      m_strobe,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data,
    input  logic [NUM_MASTERS*LEN_W-1:0]  m_len,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [NUM_MASTERS-1:0]        m_last,
    output logic [NUM_MASTERS*DATA_W-1:0] m_rdata,
    output logic                          o_valid,
    output logic                          o_is_write,
    output logic [ADDR_W-1:0]             o_addr,
    output logic [2:0]                    o_size,
    output logic [7:0]                    o_strobe,
    output logic [DATA_W-1:0]             o_data,
    output logic [LEN_W-1:0]              o_len,
    input  logic                          o_ready,
    input  logic                          o_last,
    input  logic [DATA_W-1:0]             o_rdata
);

    localparam int unsigned SEL_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] rr_last;
    logic [SEL_W-1:0] rr_last_nxt;
    logic [SEL_W-1:0] winner;
    logic             found;

    // Round-robin scan starting just after the last-served master
    always_comb begin
        int unsigned idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = (32'(rr_last) + k) % NUM_MASTERS;
            if (!found && m_valid[SEL_W'(idx)]) begin
                found  = 1'b1;
                winner = SEL_W'(idx);
            end
        end
    end

    // Next-state and bus routing; everything is quiet outside BUSY
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        rr_last_nxt = rr_last;
        o_valid     = 1'b0;
        o_is_write  = 1'b0;
        o_addr      = '0;
        o_size      = '0;
        o_strobe    = '0;
        o_data      = '0;
        o_len       = '0;
        m_ready     = '0;
        m_last      = '0;
        m_rdata     = '0;

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BUSY;
                    sel_nxt   = winner;
                end
            end
            BUSY: begin
                o_valid    = m_valid[sel];
                o_is_write = m_is_write[sel];
                o_addr     = m_addr[sel*ADDR_W +: ADDR_W];
                o_size     = m_size[sel*3 +: 3];
                o_strobe   = m_strobe[sel*8 +: 8];
                o_data     = m_data[sel*DATA_W +: DATA_W];
                o_len      = m_len[sel*LEN_W +: LEN_W];
                m_ready[sel]                   = o_ready;
                m_last[sel]                    = o_last;
                m_rdata[sel*DATA_W +: DATA_W]  = o_rdata;
                // Beat counting is left to the downstream model; only the last handshake matters here
                if (o_ready && o_last) begin
                    state_nxt   = IDLE;
                    rr_last_nxt = sel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sel     <= '0;
            rr_last <= SEL_W'(NUM_MASTERS - 1);
        end else begin
            state   <= state_nxt;
            sel     <= sel_nxt;
            rr_last <= rr_last_nxt;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Scoreboard bench for cbus_arbiter: expected bursts are queued in grant order and
// checked beat by beat against a small downstream memory model.
module tb_cbus_arbiter;

    logic          clk;
    logic          reset;
    logic [1:0]    m_valid;
    logic [1:0]    m_is_write;
    logic [127:0]  m_addr;
    logic [5:0]    m_size;
    logic [15:0]   m_strobe;
    logic [127:0]  m_data;
    logic [7:0]    m_len;
    logic [1:0]    m_ready;
    logic [1:0]    m_last;
    logic [127:0]  m_rdata;
    logic          o_valid;
    logic          o_is_write;
    logic [63:0]   o_addr;
    logic [2:0]    o_size;
    logic [7:0]    o_strobe;
    logic [63:0]   o_data;
    logic [3:0]    o_len;
    logic          o_ready;
    logic          o_last;
    logic [63:0]   o_rdata;

    typedef struct {
        int          m;
        logic        wr;
        logic [63:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        bit          b2b;
    } rec_t;

    rec_t exp_q[$];
    int   n_chk;
    int   n_pass;
    int   done_cnt;
    int   target;
    bit   stall;

    cbus_arbiter dut (
        .clk(clk), .reset(reset),
        .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr), .m_size(m_size),
        .m_strobe(m_strobe), .m_data(m_data), .m_len(m_len),
        .m_ready(m_ready), .m_last(m_last), .m_rdata(m_rdata),
        .o_valid(o_valid), .o_is_write(o_is_write), .o_addr(o_addr), .o_size(o_size),
        .o_strobe(o_strobe), .o_data(o_data), .o_len(o_len),
        .o_ready(o_ready), .o_last(o_last), .o_rdata(o_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive a master's request fields and queue the burst it should produce
    task automatic req(input int m, input logic wr, input logic [63:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [7:0] strobe, input logic [63:0] data,
                       input bit b2b);
        rec_t r;
        m_is_write[m]        = wr;
        m_addr[m*64 +: 64]   = addr;
        m_len[m*4 +: 4]      = len;
        m_size[m*3 +: 3]     = size;
        m_strobe[m*8 +: 8]   = strobe;
        m_data[m*64 +: 64]   = data;
        m_valid[m]           = 1'b1;
        r.m = m; r.wr = wr; r.addr = addr; r.len = len;
        r.size = size; r.strobe = strobe; r.data = data; r.b2b = b2b;
        exp_q.push_back(r);
    endtask

    task automatic wait_bursts(input int tgt);
        int n;
        n = 0;
        while (done_cnt < tgt && n < 500) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("burst_done", 64'(done_cnt), 64'(tgt));
    endtask

    task automatic drop(input logic [1:0] mask);
        @(posedge clk);
        #1;
        m_valid = m_valid & ~mask;
    endtask

    // Downstream memory model: returns (beat+1)*0x11 and flags the last beat
    initial begin
        int  mbeat;
        bit  tog;
        mbeat = 0;
        tog = 1'b0;
        o_ready = 1'b0; o_last = 1'b0; o_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mbeat = 0; tog = 1'b0;
                o_ready = 1'b0; o_last = 1'b0; o_rdata = '0;
            end else if (o_valid) begin
                tog     = ~tog;
                o_ready = !(stall && tog);
                o_last  = o_ready && (mbeat == int'(o_len));
                o_rdata = 64'((mbeat + 1) * 17);
            end else begin
                o_ready = 1'b0; o_last = 1'b0; o_rdata = '0;
            end
            @(posedge clk);
            if (o_ready) mbeat = o_last ? 0 : mbeat + 1;
        end
    end

    // Scoreboard consumer
    initial begin
        rec_t cur;
        bit   in_burst;
        int   beat;
        int   idle_cnt;
        in_burst = 1'b0; beat = 0; idle_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                in_burst = 1'b0;
                idle_cnt = 0;
                chk("rst_addr", o_addr, 64'(0));
                chk("rst_ctl", 64'({o_valid, o_is_write, o_size, o_strobe, o_len, m_ready, m_last}), 64'(0));
                chk("rst_rdata", m_rdata[63:0] | m_rdata[127:64], 64'(0));
            end else if (o_valid) begin
                if (!in_burst) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_grant", 64'(1), 64'(0));
                        continue;
                    end
                    cur = exp_q.pop_front();
                    in_burst = 1'b1;
                    beat = 0;
                    if (cur.b2b) chk("gap", 64'(idle_cnt), 64'(1));
                end
                chk("addr", o_addr, cur.addr);
                chk("ctl", 64'({o_is_write, o_len, o_size, o_strobe}),
                    64'({cur.wr, cur.len, cur.size, cur.strobe}));
                chk("wdata", o_data, cur.data);
                chk("m_ready", 64'(m_ready), o_ready ? (64'(1) << cur.m) : 64'(0));
                chk("m_last", 64'(m_last), o_last ? (64'(1) << cur.m) : 64'(0));
                chk("rdata_sel", m_rdata[cur.m*64 +: 64], 64'((beat + 1) * 17));
                chk("rdata_other", m_rdata[(1-cur.m)*64 +: 64], 64'(0));
                if (o_ready) begin
                    if (o_last) begin
                        chk("beats", 64'(beat), 64'(cur.len));
                        in_burst = 1'b0;
                        idle_cnt = 0;
                        done_cnt++;
                    end else begin
                        beat++;
                    end
                end
            end else begin
                idle_cnt++;
                chk("idle_out", o_addr | o_data | 64'({o_is_write, o_size, o_strobe, o_len}), 64'(0));
                chk("idle_resp", 64'({m_ready, m_last}), 64'(0));
            end
        end
    end

    initial begin
        n_chk = 0; n_pass = 0; done_cnt = 0; target = 0; stall = 1'b0;
        reset = 1'b0;
        m_valid = '0; m_is_write = '0; m_addr = '0; m_size = '0;
        m_strobe = '0; m_data = '0; m_len = '0;

        // Both masters requesting through reset: master 0 must win first
        req(0, 1'b0, 64'h0000_0000_1000_0000, 4'd0, 3'd3, 8'hFF, 64'h0101, 1'b0);
        req(1, 1'b0, 64'h0000_0000_9000_0000, 4'd0, 3'd3, 8'hFF, 64'h0202, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk); #3;
        chk("lat_idle", 64'(o_valid), 64'(0));
        @(negedge clk); #3;
        chk("lat_grant", 64'(o_valid), 64'(1));
        chk("lat_addr", o_addr, 64'h0000_0000_1000_0000);
        target += 1; wait_bursts(target); drop(2'b01);
        target += 1; wait_bursts(target); drop(2'b10);

        // Master 1 alone, 4-beat read
        req(1, 1'b0, 64'h0000_0000_8000_0040, 4'd3, 3'd3, 8'hFF, 64'h0, 1'b0);
        target += 1; wait_bursts(target); drop(2'b10);

        // Both masters continuously valid with single-beat bursts: strict alternation
        req(0, 1'b0, 64'h0000_0000_1000_0100, 4'd0, 3'd2, 8'h0F, 64'h33, 1'b0);
        req(1, 1'b1, 64'h0000_0000_8000_0100, 4'd0, 3'd2, 8'hF0, 64'h44, 1'b1);
        req(0, 1'b0, 64'h0000_0000_1000_0100, 4'd0, 3'd2, 8'h0F, 64'h33, 1'b1);
        req(1, 1'b1, 64'h0000_0000_8000_0100, 4'd0, 3'd2, 8'hF0, 64'h44, 1'b1);
        target += 4; wait_bursts(target); drop(2'b11);

        // Long write on master 0; master 1 arrives mid-burst and must wait
        req(0, 1'b1, 64'h0000_0000_1000_0200, 4'd7, 3'd3, 8'hFF, 64'h1234_5678, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        req(1, 1'b0, 64'h0000_0000_8000_0200, 4'd1, 3'd3, 8'hFF, 64'h0, 1'b1);
        target += 1; wait_bursts(target); drop(2'b01);
        target += 1; wait_bursts(target); drop(2'b10);

        // Write pass-through with a stalling downstream
        stall = 1'b1;
        req(1, 1'b1, 64'h0000_0000_8000_0300, 4'd1, 3'd3, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        target += 1; wait_bursts(target); drop(2'b10);
        stall = 1'b0;
        req(0, 1'b0, 64'h0000_0000_1000_0300, 4'd0, 3'd3, 8'hFF, 64'h0, 1'b0);
        target += 1; wait_bursts(target); drop(2'b01);

        // Reset in the middle of a burst, then re-arbitration from the reset pointer
        req(1, 1'b0, 64'h0000_0000_8000_0400, 4'd3, 3'd3, 8'hFF, 64'h0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", 64'({o_valid, m_ready, m_last}), 64'(0));
        chk("midrst_addr", o_addr, 64'(0));
        chk("midrst_rdata", m_rdata[127:64], 64'(0));
        m_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        req(0, 1'b0, 64'h0000_0000_1000_0500, 4'd1, 3'd3, 8'hFF, 64'h0, 1'b0);
        req(1, 1'b0, 64'h0000_0000_8000_0500, 4'd1, 3'd3, 8'hFF, 64'h0, 1'b0);
        target += 1; wait_bursts(target); drop(2'b01);
        target += 1; wait_bursts(target); drop(2'b10);

        repeat (3) @(posedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
